// File: rtl/write_back_stage.sv
// Write-back stage: selects the write-back value, owns the register file with
// write-through read ports, and reassembles popped PC words / restores CCR.
module write_back_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int PC_W     = 32,
    parameter int CCR_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dataFromMemory_WB,
    input  logic [DATA_W-1:0] MEMWB_ALU_result_wB,
    input  logic [ADDR_W-1:0] MEMWB_Rdst_address_WB,
    input  logic              MEMWB_memRead_WB,
    input  logic              MEMWB_WB,
    input  logic              Pop_WB,
    input  logic              popPc_WB,
    input  logic              popCCR_WB,
    input  logic [ADDR_W-1:0] Rsrc1_address,
    input  logic [ADDR_W-1:0] Rsrc2_address,
    output logic [DATA_W-1:0] Rsrc1_data,
    output logic [DATA_W-1:0] Rsrc2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_value,
    output logic              pc_pop_pending,
    output logic              ccr_load,
    output logic [CCR_W-1:0]  ccr_value
);

    typedef enum logic {IDLE, HI_HELD} pc_state_t;

    pc_state_t         state, state_next;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] pc_hi;
    logic              wr_en;
    logic              capture_hi;
    logic              complete_pc;
    logic              pop_unused;

    // The pop flag only qualifies stack traffic upstream; nothing here depends on it.
    assign pop_unused = Pop_WB;

    assign wb_data = MEMWB_memRead_WB ? dataFromMemory_WB : MEMWB_ALU_result_wB;
    assign wr_en   = MEMWB_WB && !popPc_WB && !popCCR_WB;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[MEMWB_Rdst_address_WB] <= wb_data;
        end
    end

    always_comb begin
        Rsrc1_data = regs[Rsrc1_address];
        Rsrc2_data = regs[Rsrc2_address];
        if (wr_en && (MEMWB_Rdst_address_WB == Rsrc1_address)) Rsrc1_data = wb_data;
        if (wr_en && (MEMWB_Rdst_address_WB == Rsrc2_address)) Rsrc2_data = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        capture_hi  = 1'b0;
        complete_pc = 1'b0;
        case (state)
            IDLE: begin
                if (popPc_WB) begin
                    capture_hi = 1'b1;
                    state_next = HI_HELD;
                end
            end
            HI_HELD: begin
                if (popPc_WB) begin
                    complete_pc = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pc_pop_pending = (state == HI_HELD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_hi     <= '0;
            pc_value  <= '0;
            pc_load   <= 1'b0;
            ccr_value <= '0;
            ccr_load  <= 1'b0;
        end else begin
            pc_load  <= complete_pc;
            ccr_load <= popCCR_WB;
            if (capture_hi)  pc_hi    <= wb_data;
            if (complete_pc) pc_value <= {pc_hi, wb_data};
            if (popCCR_WB)   ccr_value <= wb_data[CCR_W-1:0];
        end
    end

endmodule
